// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of system_ram. A granted
// master keeps the bus until its cycle ends or it hits the beat limit.
module wb_ram_arbiter #(
  parameter int MAX_BEATS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wbs_stb_i_ram_cpu,
  input  logic                wbs_cyc_i_ram_cpu,
  input  logic                wbs_we_i_ram_cpu,
  input  logic [DATA_W/8-1:0] wbs_sel_i_ram_cpu,
  input  logic [DATA_W-1:0]   wbs_dat_i_ram_cpu,
  input  logic [ADDR_W-1:0]   wbs_adr_i_ram_cpu,
  output logic                wbs_ack_o_ram_cpu,
  output logic [DATA_W-1:0]   wbs_dat_o_ram_cpu,
  input  logic                wbs_stb_i_ram_dma,
  input  logic                wbs_cyc_i_ram_dma,
  input  logic                wbs_we_i_ram_dma,
  input  logic [DATA_W/8-1:0] wbs_sel_i_ram_dma,
  input  logic [DATA_W-1:0]   wbs_dat_i_ram_dma,
  input  logic [ADDR_W-1:0]   wbs_adr_i_ram_dma,
  output logic                wbs_ack_o_ram_dma,
  output logic [DATA_W-1:0]   wbs_dat_o_ram_dma,
  output logic                wbs_stb_o_ram,
  output logic                wbs_cyc_o_ram,
  output logic                wbs_we_o_ram,
  output logic [DATA_W/8-1:0] wbs_sel_o_ram,
  output logic [DATA_W-1:0]   wbs_dat_o_ram,
  output logic [ADDR_W-1:0]   wbs_adr_o_ram,
  input  logic                wbs_ack_i_ram,
  input  logic [DATA_W-1:0]   wbs_dat_i_ram,
  output logic [1:0]          gnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, G_CPU = 2'd1, G_DMA = 2'd2} state_t;

  state_t     state, state_next, other_state;
  logic       last_dma, last_dma_next;
  logic [7:0] beat_cnt, beat_cnt_next;
  logic       req_cpu, req_dma;
  logic       own_cyc, own_req, other_req, beat_ack, at_limit;

  assign req_cpu     = wbs_cyc_i_ram_cpu & wbs_stb_i_ram_cpu;
  assign req_dma     = wbs_cyc_i_ram_dma & wbs_stb_i_ram_dma;
  assign beat_ack    = own_req & wbs_ack_i_ram;
  assign at_limit    = ({1'b0, beat_cnt} + 9'd1) >= 9'(MAX_BEATS);
  assign other_state = (state == G_CPU) ? G_DMA : G_CPU;
  assign gnt         = {state == G_DMA, state == G_CPU};

  // Slave-side mux and return routing; acks that match no forwarded strobe are dropped.
  always_comb begin
    wbs_stb_o_ram     = 1'b0;
    wbs_cyc_o_ram     = 1'b0;
    wbs_we_o_ram      = 1'b0;
    wbs_sel_o_ram     = '0;
    wbs_dat_o_ram     = '0;
    wbs_adr_o_ram     = '0;
    wbs_ack_o_ram_cpu = 1'b0;
    wbs_dat_o_ram_cpu = '0;
    wbs_ack_o_ram_dma = 1'b0;
    wbs_dat_o_ram_dma = '0;
    own_cyc           = 1'b0;
    own_req           = 1'b0;
    other_req         = 1'b0;
    case (state)
      G_CPU: begin
        wbs_stb_o_ram     = wbs_stb_i_ram_cpu;
        wbs_cyc_o_ram     = wbs_cyc_i_ram_cpu;
        wbs_we_o_ram      = wbs_we_i_ram_cpu;
        wbs_sel_o_ram     = wbs_sel_i_ram_cpu;
        wbs_dat_o_ram     = wbs_dat_i_ram_cpu;
        wbs_adr_o_ram     = wbs_adr_i_ram_cpu;
        wbs_ack_o_ram_cpu = wbs_ack_i_ram & req_cpu;
        wbs_dat_o_ram_cpu = wbs_dat_i_ram;
        own_cyc           = wbs_cyc_i_ram_cpu;
        own_req           = req_cpu;
        other_req         = req_dma;
      end
      G_DMA: begin
        wbs_stb_o_ram     = wbs_stb_i_ram_dma;
        wbs_cyc_o_ram     = wbs_cyc_i_ram_dma;
        wbs_we_o_ram      = wbs_we_i_ram_dma;
        wbs_sel_o_ram     = wbs_sel_i_ram_dma;
        wbs_dat_o_ram     = wbs_dat_i_ram_dma;
        wbs_adr_o_ram     = wbs_adr_i_ram_dma;
        wbs_ack_o_ram_dma = wbs_ack_i_ram & req_dma;
        wbs_dat_o_ram_dma = wbs_dat_i_ram;
        own_cyc           = wbs_cyc_i_ram_dma;
        own_req           = req_dma;
        other_req         = req_cpu;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    last_dma_next = last_dma;
    case (state)
      IDLE: begin
        beat_cnt_next = '0;
        if (req_cpu && (!req_dma || last_dma)) state_next = G_CPU;
        else if (req_dma)                      state_next = G_DMA;
      end
      G_CPU, G_DMA: begin
        if (!own_cyc) begin
          beat_cnt_next = '0;
          state_next    = other_req ? other_state : IDLE;
        end else if (beat_ack) begin
          if (other_req && at_limit) begin
            beat_cnt_next = '0;
            state_next    = other_state;
          end else if (beat_cnt != 8'hFF) begin
            beat_cnt_next = beat_cnt + 8'd1;
          end
        end
      end
      default: begin
        beat_cnt_next = '0;
        state_next    = IDLE;
      end
    endcase
    if (state_next == G_CPU)      last_dma_next = 1'b0;
    else if (state_next == G_DMA) last_dma_next = 1'b1;
  end

  // Reset leaves DMA as last owner so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_dma <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      last_dma <= last_dma_next;
      beat_cnt <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed scenarios with literal expectations, then
// random bursts checked every cycle against an ownership-level model.
module tb_wb_ram_arbiter;
  localparam int MAX_BEATS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_stb, cpu_cyc, cpu_we, cpu_ack;
  logic [3:0] cpu_sel;
  logic [31:0] cpu_dat, cpu_adr, cpu_rdat;
  logic dma_stb, dma_cyc, dma_we, dma_ack;
  logic [3:0] dma_sel;
  logic [31:0] dma_dat, dma_adr, dma_rdat;
  logic ram_stb, ram_cyc, ram_we, ram_ack;
  logic [3:0] ram_sel;
  logic [31:0] ram_wdat, ram_adr, ram_rdat;
  logic [1:0] gnt;

  int vectors = 0;
  int miscompares = 0;

  // owner: 0 none, 1 cpu, 2 dma
  int m_owner, m_last, m_beats, n_owner, n_last, n_beats, m_other;
  logic m_hit, cpu_acked, dma_acked;

  logic m_busy [2];
  int m_left [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic m_we [2];
  logic [3:0] m_sel [2];
  logic [31:0] ack_log [$];
  logic [31:0] exp_log [11];

  wb_ram_arbiter #(.MAX_BEATS(MAX_BEATS), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i_ram_cpu(cpu_stb), .wbs_cyc_i_ram_cpu(cpu_cyc), .wbs_we_i_ram_cpu(cpu_we),
    .wbs_sel_i_ram_cpu(cpu_sel), .wbs_dat_i_ram_cpu(cpu_dat), .wbs_adr_i_ram_cpu(cpu_adr),
    .wbs_ack_o_ram_cpu(cpu_ack), .wbs_dat_o_ram_cpu(cpu_rdat),
    .wbs_stb_i_ram_dma(dma_stb), .wbs_cyc_i_ram_dma(dma_cyc), .wbs_we_i_ram_dma(dma_we),
    .wbs_sel_i_ram_dma(dma_sel), .wbs_dat_i_ram_dma(dma_dat), .wbs_adr_i_ram_dma(dma_adr),
    .wbs_ack_o_ram_dma(dma_ack), .wbs_dat_o_ram_dma(dma_rdat),
    .wbs_stb_o_ram(ram_stb), .wbs_cyc_o_ram(ram_cyc), .wbs_we_o_ram(ram_we),
    .wbs_sel_o_ram(ram_sel), .wbs_dat_o_ram(ram_wdat), .wbs_adr_o_ram(ram_adr),
    .wbs_ack_i_ram(ram_ack), .wbs_dat_i_ram(ram_rdat),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  function automatic logic m_req(input int who);
    if (who == 1) return cpu_cyc & cpu_stb;
    if (who == 2) return dma_cyc & dma_stb;
    return 1'b0;
  endfunction

  function automatic logic m_cyc(input int who);
    if (who == 1) return cpu_cyc;
    if (who == 2) return dma_cyc;
    return 1'b0;
  endfunction

  function automatic logic slave_sees();
    return (m_owner != 0) && m_req(m_owner);
  endfunction

  // Ownership rules: round-robin from idle, release on cyc drop, handover at the beat limit.
  always_comb begin
    n_owner = m_owner;
    n_last  = m_last;
    n_beats = m_beats;
    m_other = 3 - m_owner;
    m_hit   = (m_owner != 0) && ram_ack && m_req(m_owner);
    if (m_owner == 0) begin
      n_beats = 0;
      if (m_req(1) && m_req(2)) n_owner = (m_last == 1) ? 2 : 1;
      else if (m_req(1))        n_owner = 1;
      else if (m_req(2))        n_owner = 2;
    end else if (!m_cyc(m_owner)) begin
      n_owner = m_req(m_other) ? m_other : 0;
      n_beats = 0;
    end else if (m_hit) begin
      if (m_req(m_other) && (m_beats + 1 >= MAX_BEATS)) begin
        n_owner = m_other;
        n_beats = 0;
      end else begin
        n_beats = (m_beats < 255) ? m_beats + 1 : m_beats;
      end
    end
    if (n_owner != 0) n_last = n_owner;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner   <= 0;
      m_last    <= 2;
      m_beats   <= 0;
      cpu_acked <= 1'b0;
      dma_acked <= 1'b0;
    end else begin
      m_owner   <= n_owner;
      m_last    <= n_last;
      m_beats   <= n_beats;
      cpu_acked <= m_hit && (m_owner == 1);
      dma_acked <= m_hit && (m_owner == 2);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [1:0] e_gnt = 2'b00;
    logic e_stb = 1'b0, e_cyc = 1'b0, e_we = 1'b0;
    logic [3:0] e_sel = 4'h0;
    logic [31:0] e_wdat = '0, e_adr = '0;
    if (m_owner == 1) begin
      e_gnt = 2'b01; e_stb = cpu_stb; e_cyc = cpu_cyc; e_we = cpu_we;
      e_sel = cpu_sel; e_wdat = cpu_dat; e_adr = cpu_adr;
    end else if (m_owner == 2) begin
      e_gnt = 2'b10; e_stb = dma_stb; e_cyc = dma_cyc; e_we = dma_we;
      e_sel = dma_sel; e_wdat = dma_dat; e_adr = dma_adr;
    end
    check_output("gnt", gnt, e_gnt);
    check_output("ram_stb", ram_stb, e_stb);
    check_output("ram_cyc", ram_cyc, e_cyc);
    check_output("ram_we", ram_we, e_we);
    check_output("ram_sel", ram_sel, e_sel);
    check_output("ram_wdat", ram_wdat, e_wdat);
    check_output("ram_adr", ram_adr, e_adr);
    check_output("cpu_ack", cpu_ack, (m_owner == 1) && ram_ack && cpu_cyc && cpu_stb);
    check_output("dma_ack", dma_ack, (m_owner == 2) && ram_ack && dma_cyc && dma_stb);
    check_output("cpu_rdat", cpu_rdat, (m_owner == 1) ? ram_rdat : 32'h0);
    check_output("dma_rdat", dma_rdat, (m_owner == 2) ? ram_rdat : 32'h0);
  endtask

  always @(negedge clk) begin
    #2;
    compare_all();
  end

  task automatic start_burst(input int m, input int len, input logic [31:0] adr,
                             input logic we, input logic [3:0] sel, input logic [31:0] dat);
    m_busy[m] = 1'b1;
    m_left[m] = len;
    m_adr[m]  = adr;
    m_we[m]   = we;
    m_sel[m]  = sel;
    m_dat[m]  = dat;
  endtask

  task automatic drive_masters();
    cpu_cyc = m_busy[0]; cpu_stb = m_busy[0]; cpu_we = m_we[0];
    cpu_sel = m_sel[0];  cpu_dat = m_dat[0];  cpu_adr = m_adr[0];
    dma_cyc = m_busy[1]; dma_stb = m_busy[1]; dma_we = m_we[1];
    dma_sel = m_sel[1];  dma_dat = m_dat[1];  dma_adr = m_adr[1];
  endtask

  task automatic next_cycle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (m_busy[m] && ((m == 0) ? cpu_acked : dma_acked)) begin
        m_left[m]--;
        m_adr[m] += 32'd4;
        m_dat[m] = $urandom;
        if (m_left[m] == 0) m_busy[m] = 1'b0;
      end
    end
  endtask

  // ack_mode: 0 none, 1 whenever a strobe is forwarded, 2 random wait states, 3 stray ack
  task automatic apply_stimulus(input int ack_mode, input logic [31:0] rdat);
    drive_masters();
    case (ack_mode)
      1:       ram_ack = slave_sees();
      2:       ram_ack = slave_sees() && ($urandom_range(2) != 0);
      3:       ram_ack = 1'b1;
      default: ram_ack = 1'b0;
    endcase
    ram_rdat = rdat;
    #3;
  endtask

  initial begin
    int n_dma, reset_hold;
    logic cpu_started, t4_done;
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 1'b0; m_left[m] = 0; m_adr[m] = '0;
      m_dat[m] = '0; m_we[m] = 1'b0; m_sel[m] = 4'h0;
    end
    drive_masters();
    ram_ack = 1'b0;
    ram_rdat = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a DMA beat.
    next_cycle(); start_burst(1, 1, 32'h3800_0100, 1'b0, 4'hF, 32'h0); apply_stimulus(0, 32'h0);
    check_output("t1 idle gnt", gnt, 2'b00);
    next_cycle(); apply_stimulus(0, 32'h5555_0000);
    check_output("t1 dma gnt", gnt, 2'b10);
    check_output("t1 dma stb", ram_stb, 1'b1);
    next_cycle(); apply_stimulus(0, 32'h5555_0001);
    rst_n = 1'b0;
    #1;
    check_output("t1 rst gnt", gnt, 2'b00);
    check_output("t1 rst stb", ram_stb, 1'b0);
    check_output("t1 rst cyc", ram_cyc, 1'b0);
    check_output("t1 rst adr", ram_adr, 32'h0);
    next_cycle(); apply_stimulus(3, 32'h1111_1111);
    check_output("t1 rst ack", dma_ack, 1'b0);
    check_output("t1 rst rdat", dma_rdat, 32'h0);
    next_cycle(); m_busy[1] = 1'b0; rst_n = 1'b1; apply_stimulus(3, 32'h2222_2222);
    check_output("t1 post ack", dma_ack, 1'b0);
    check_output("t1 post gnt", gnt, 2'b00);

    // Simultaneous requests right after reset: CPU first, then DMA.
    next_cycle();
    start_burst(0, 1, 32'h3800_0020, 1'b0, 4'hF, 32'h0);
    start_burst(1, 1, 32'h3800_0120, 1'b0, 4'hF, 32'h0);
    apply_stimulus(0, 32'h0);
    check_output("t3 idle gnt", gnt, 2'b00);
    next_cycle(); apply_stimulus(1, 32'hA0A0_A0A0);
    check_output("t3 cpu gnt", gnt, 2'b01);
    check_output("t3 cpu adr", ram_adr, 32'h3800_0020);
    check_output("t3 cpu ack", cpu_ack, 1'b1);
    check_output("t3 dma held", dma_ack, 1'b0);
    check_output("t3 cpu rdat", cpu_rdat, 32'hA0A0_A0A0);
    next_cycle(); apply_stimulus(1, 32'h0);
    check_output("t3 release gnt", gnt, 2'b01);
    check_output("t3 release cyc", ram_cyc, 1'b0);
    next_cycle(); apply_stimulus(1, 32'hB0B0_B0B0);
    check_output("t3 dma gnt", gnt, 2'b10);
    check_output("t3 dma adr", ram_adr, 32'h3800_0120);
    check_output("t3 dma ack", dma_ack, 1'b1);
    check_output("t3 dma rdat", dma_rdat, 32'hB0B0_B0B0);
    next_cycle(); apply_stimulus(0, 32'h0);
    next_cycle(); apply_stimulus(0, 32'h0);
    check_output("t3 idle again", gnt, 2'b00);

    // CPU-only read.
    next_cycle(); start_burst(0, 1, 32'h3800_0010, 1'b0, 4'hF, 32'h0); apply_stimulus(0, 32'h0);
    check_output("t2 idle gnt", gnt, 2'b00);
    next_cycle(); apply_stimulus(1, 32'hDEAD_BEEF);
    check_output("t2 gnt", gnt, 2'b01);
    check_output("t2 adr", ram_adr, 32'h3800_0010);
    check_output("t2 we", ram_we, 1'b0);
    check_output("t2 cpu ack", cpu_ack, 1'b1);
    check_output("t2 cpu rdat", cpu_rdat, 32'hDEAD_BEEF);
    check_output("t2 dma ack", dma_ack, 1'b0);
    check_output("t2 dma rdat", dma_rdat, 32'h0);
    next_cycle(); apply_stimulus(0, 32'h0);
    next_cycle(); apply_stimulus(0, 32'h0);
    check_output("t2 end gnt", gnt, 2'b00);

    // CPU write while DMA waits.
    next_cycle(); start_burst(0, 1, 32'h3800_0030, 1'b1, 4'b0011, 32'h1234_5678); apply_stimulus(0, 32'h0);
    next_cycle(); start_burst(1, 1, 32'h3800_0200, 1'b0, 4'hF, 32'hCAFE_F00D); apply_stimulus(0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin next_cycle(); apply_stimulus(1, 32'h0); end
      check_output("t6 gnt", gnt, 2'b01);
      check_output("t6 we", ram_we, 1'b1);
      check_output("t6 sel", ram_sel, 4'b0011);
      check_output("t6 wdat", ram_wdat, 32'h1234_5678);
      check_output("t6 adr", ram_adr, 32'h3800_0030);
      check_output("t6 dma ack", dma_ack, 1'b0);
    end
    check_output("t6 cpu ack", cpu_ack, 1'b1);
    next_cycle(); apply_stimulus(1, 32'h0);
    next_cycle(); apply_stimulus(1, 32'h0);
    check_output("t6 dma gnt", gnt, 2'b10);
    check_output("t6 dma wdat", ram_wdat, 32'hCAFE_F00D);
    check_output("t6 dma ack", dma_ack, 1'b1);
    next_cycle(); apply_stimulus(0, 32'h0);
    next_cycle(); apply_stimulus(0, 32'h0);
    check_output("t6 end gnt", gnt, 2'b00);

    // Ten-beat DMA burst preempted by a CPU beat at the limit.
    n_dma = 0; cpu_started = 1'b0; t4_done = 1'b0;
    next_cycle(); start_burst(1, 10, 32'h3800_1000, 1'b0, 4'hF, $urandom); apply_stimulus(1, $urandom);
    for (int i = 0; i < 60 && !t4_done; i++) begin
      next_cycle();
      if (dma_acked) n_dma++;
      if (n_dma == 2 && !cpu_started) begin
        start_burst(0, 1, 32'h3800_2000, 1'b1, 4'hF, $urandom);
        cpu_started = 1'b1;
      end
      apply_stimulus(1, $urandom);
      if (cpu_ack || dma_ack) ack_log.push_back(ram_adr);
      if (cpu_started && !m_busy[0] && !m_busy[1]) t4_done = 1'b1;
    end
    check_output("t4 done", t4_done, 1'b1);
    exp_log = '{32'h3800_1000, 32'h3800_1004, 32'h3800_1008, 32'h3800_100C, 32'h3800_2000,
                32'h3800_1010, 32'h3800_1014, 32'h3800_1018, 32'h3800_101C, 32'h3800_1020,
                32'h3800_1024};
    check_output("t4 beats", ack_log.size(), 11);
    for (int i = 0; i < 11 && i < ack_log.size(); i++) check_output("t4 adr seq", ack_log[i], exp_log[i]);

    // Uncontested DMA burst keeps the grant throughout.
    next_cycle(); start_burst(1, 10, 32'h3800_3000, 1'b0, 4'hF, $urandom); apply_stimulus(1, $urandom);
    for (int i = 0; i < 10; i++) begin
      next_cycle(); apply_stimulus(1, $urandom);
      check_output("t5 gnt", gnt, 2'b10);
      check_output("t5 ack", dma_ack, 1'b1);
    end
    next_cycle(); apply_stimulus(0, 32'h0);
    next_cycle(); apply_stimulus(0, 32'h0);
    check_output("t5 end gnt", gnt, 2'b00);

    // Random contention, aborts and occasional asynchronous resets.
    reset_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (reset_hold > 0) begin
        reset_hold--;
        if (reset_hold == 0) rst_n = 1'b1;
      end
      for (int m = 0; m < 2; m++) begin
        if (!m_busy[m] && $urandom_range(3) == 0)
          start_burst(m, $urandom_range(8, 1), 32'h3800_0000 | ($urandom_range(1023) << 2),
                      1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
        else if (m_busy[m] && $urandom_range(31) == 0)
          m_busy[m] = 1'b0;
      end
      apply_stimulus(2, $urandom);
      if (rst_n && $urandom_range(299) == 0) begin
        rst_n = 1'b0;
        m_busy[0] = 1'b0;
        m_busy[1] = 1'b0;
        drive_masters();
        reset_hold = 2;
      end
    end
    rst_n = 1'b1;
    next_cycle(); apply_stimulus(0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
